sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Initiator-side controller between the ARM pipeline MEM stage and the external 64-bit-read / 32-bit-write SRAM.
- Converts single-cycle rd_en/wr_en requests into timed SRAM accesses: SRAM_WE_N, SRAM_ADDR and the SRAM_DQ bus.
- Holds ready low for a fixed wait-state count so the pipeline freezes.
- On a read, returns the addressed 32-bit word and also the full 64-bit pair.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 5: clock cycles an access occupies the SRAM bus; must be ≥1 and cover the 30 ns SRAM read delay at the target clock.
- CNT_W, 3: counter width; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- clk  in  1  system clock, all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  read request; held until ready=1
- wr_en  in  1  write request; held until ready=1
- address  in  32  byte address from the ALU
- write_data  in  32  store data
- read_data  out  32  selected load word; valid while ready=1 in DONE
- read_data64  out  64  raw pair {odd word, even word}; valid with read_data
- ready  out  1  0 = freeze pipeline
- SRAM_WE_N  out  1  SRAM write enable, active low
- SRAM_ADDR  out  17  SRAM word address
- SRAM_DQ  inout  64  SRAM data bus

Behaviour:
- Word address: waddr = ((address - BASE_ADDR) >> 2) truncated to 17 bits. Out-of-range addresses wrap modulo 2^17; no error is flagged.
- FSM has three states: IDLE, BUSY, DONE. The async reset value is IDLE.
- Reset values:
  - SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - read_data=0, read_data64=0, counter=0.
  - op register = read, wdata register = 0.
- ready is combinational:
  - IDLE: ready = ~(rd_en | wr_en).
  - BUSY: ready = 0.
  - DONE: ready = 1.
- IDLE, on posedge with (rd_en | wr_en):
  - Latch op; wr_en has priority when both are asserted.
  - Latch waddr into SRAM_ADDR and write_data into the wdata register.
  - Set counter=0 and go to BUSY.
  - SRAM_WE_N = 0 if op is write, else 1.
- BUSY, each posedge:
  - Counter increments.
  - When counter == WAIT_CYCLES-1, go to DONE and, for a read, capture SRAM_DQ into read_data64.
  - read_data = waddr[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0], captured on the same edge.
- DONE:
  - SRAM_WE_N returns to 1 on the BUSY→DONE edge.
  - read_data and read_data64 hold their values.
  - Next posedge goes to IDLE unconditionally; the request still asserted on that edge is consumed, not restarted.
- Bus drive: SRAM_DQ = {32'b0, wdata} when state==BUSY and op==write, else Z. The SRAM captures DQ[31:0] on every posedge with WE_N low, so repeated identical writes are harmless.
- Write cycles leave read_data and read_data64 unchanged.
- Total latency from request seen in IDLE to ready=1 is WAIT_CYCLES+1 edges. Back-to-back requests incur one IDLE cycle between them.
- SRAM_ADDR is stable for the whole of BUSY and DONE. rd_en, wr_en, address and write_data changes during BUSY are ignored.
- Reset asserted mid-operation:
  - Immediately returns to IDLE, sets SRAM_WE_N=1 and releases DQ to Z.
  - SRAM contents are undefined only if reset lands on a write edge.
  - No partial read data is presented.

Test Plan:
1. Reset with rd_en=wr_en=0 → ready=1, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0, read_data=0.
2. wr_en=1, address=1028, write_data=32'h0000_00AB:
   - SRAM_ADDR=1 and SRAM_WE_N=0 for exactly 5 cycles.
   - DQ[31:0]=0xAB during those cycles.
   - ready=0 for 5 cycles, then 1 in DONE.
   - SRAM mem[1]=0xAB afterwards.
3. Preload mem[0]=0x11, mem[1]=0xAB, then rd_en=1, address=1028:
   - ready=1 on the 6th edge after the request.
   - read_data=0xAB, read_data64=64'h0000_00AB_0000_0011, SRAM_WE_N stays 1.
   - Repeat with address=1024 → read_data=0x11.
4. rd_en=wr_en=1, address=1032, write_data=7 → the write is performed (mem[2]=7) and read_data is unchanged.
5. Back-to-back: a write to 1036 (data 9), then a read of 1036 as soon as ready=1 → exactly one IDLE cycle between them, then read_data=9.
6. Assert rst at BUSY counter=2 of a read → state IDLE at once, SRAM_WE_N=1, DQ=Z, read_data=0. A subsequent read completes normally.

Source files
------------

// File: rtl/sram_controller.sv
// ============================================================================
// Module      : sram_controller
// Description : Pipeline-MEM-stage SRAM initiator with fixed wait states,
//               64-bit read / 32-bit write external bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [63:0] read_data64,
    output logic        ready,
    output logic        SRAM_WE_N,
    output logic [16:0] SRAM_ADDR,
    inout  wire  [63:0] SRAM_DQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               op_wr_q,   op_wr_d;
    logic [31:0]        wdata_q,   wdata_d;
    logic [16:0]        addr_q,    addr_d;
    logic               we_n_q,    we_n_d;
    logic [31:0]        rdata_q,   rdata_d;
    logic [63:0]        rdata64_q, rdata64_d;
    logic [16:0]        w_waddr;

    // Out-of-window addresses simply wrap into the 17-bit word space.
    assign w_waddr = 17'((address - 32'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
            we_n_q    <= 1'b1;
            rdata_q   <= '0;
            rdata64_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            we_n_q    <= we_n_d;
            rdata_q   <= rdata_d;
            rdata64_q <= rdata64_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        we_n_d    = we_n_q;
        rdata_d   = rdata_q;
        rdata64_d = rdata64_q;
        ready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = ~(rd_en | wr_en);
                if (rd_en | wr_en) begin
                    op_wr_d = wr_en;
                    addr_d  = w_waddr;
                    wdata_d = write_data;
                    cnt_d   = '0;
                    we_n_d  = ~wr_en;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_DONE;
                    we_n_d  = 1'b1;
                    // Sample on the last wait cycle so the SRAM access time is covered.
                    if (!op_wr_q) begin
                        rdata64_d = SRAM_DQ;
                        rdata_d   = addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
                    end
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign SRAM_DQ     = (state_q == ST_BUSY && op_wr_q) ? {32'b0, wdata_q} : 64'bz;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_ADDR   = addr_q;
    assign read_data   = rdata_q;
    assign read_data64 = rdata64_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module      : tb_sram_controller
// Description : Directed self-checking bench for sram_controller with a
//               small behavioural SRAM on the shared data bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic [63:0] read_data64;
    logic        ready;
    logic        sram_we_n;
    logic [16:0] sram_addr;
    wire  [63:0] sram_dq;

    int total = 0;
    int bad   = 0;
    int edges, we_lo;

    logic [31:0] mem [0:15];
    logic        mem_clr;

    sram_controller #(
        .BASE_ADDR   (1024),
        .WAIT_CYCLES (5),
        .CNT_W       (3)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .read_data64 (read_data64),
        .ready       (ready),
        .SRAM_WE_N   (sram_we_n),
        .SRAM_ADDR   (sram_addr),
        .SRAM_DQ     (sram_dq)
    );

    always #5 clk = ~clk;

    // SRAM model: writes low half on every edge with WE_N low, drives the pair otherwise.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (!sram_we_n) begin
            mem[sram_addr[3:0]] <= sram_dq[31:0];
        end
    end

    assign sram_dq = sram_we_n ? {mem[{sram_addr[3:1], 1'b1}], mem[{sram_addr[3:1], 1'b0}]}
                               : 64'bz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [16:0] exp_waddr,
                              output int n_edges, output int n_we);
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = d;
        n_edges    = 0;
        n_we       = 0;
        while (n_edges < 20) begin
            tick();
            n_edges++;
            if (!sram_we_n) begin
                n_we++;
                check("busy_dq_wdata", 64'(sram_dq[31:0]), 64'(d));
                check("busy_addr", 64'(sram_addr), 64'(exp_waddr));
            end
            if (ready) break;
        end
        if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic drop_req();
        rd_en = 1'b0;
        wr_en = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        mem_clr    = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        tick();
        tick();
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Reset state
        check("rst_ready",  64'(ready),      64'd1);
        check("rst_we_n",   64'(sram_we_n),  64'd1);
        check("rst_addr",   64'(sram_addr),  64'd0);
        check("rst_rdata",  64'(read_data),  64'd0);
        check("rst_rdata64", read_data64,    64'd0);
        check("rst_dq",      sram_dq,        64'd0);

        // Write 0xAB to word 1
        run_access(1'b0, 1'b1, 32'd1028, 32'h0000_00AB, 17'd1, edges, we_lo);
        check("wr_latency", 64'(edges),     64'd6);
        check("wr_we_cycles", 64'(we_lo),   64'd5);
        check("wr_done_addr", 64'(sram_addr), 64'd1);
        check("wr_done_we_n", 64'(sram_we_n), 64'd1);
        drop_req();
        check("wr_mem1", 64'(mem[1]), 64'h0000_00AB);

        // Preload word 0 through the controller
        run_access(1'b0, 1'b1, 32'd1024, 32'h0000_0011, 17'd0, edges, we_lo);
        drop_req();
        check("pre_mem0", 64'(mem[0]), 64'h0000_0011);

        // Reads of the odd and even word of the pair
        run_access(1'b1, 1'b0, 32'd1028, 32'd0, 17'd1, edges, we_lo);
        check("rd1_latency", 64'(edges), 64'd6);
        check("rd1_we_cycles", 64'(we_lo), 64'd0);
        check("rd1_rdata", 64'(read_data), 64'h0000_00AB);
        check("rd1_rdata64", read_data64, 64'h0000_00AB_0000_0011);
        check("rd1_bus_released", sram_dq, 64'h0000_00AB_0000_0011);
        drop_req();
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, 17'd0, edges, we_lo);
        check("rd0_rdata", 64'(read_data), 64'h0000_0011);
        check("rd0_rdata64", read_data64, 64'h0000_00AB_0000_0011);
        drop_req();

        // Simultaneous read and write: write wins
        run_access(1'b1, 1'b1, 32'd1032, 32'd7, 17'd2, edges, we_lo);
        check("both_we_cycles", 64'(we_lo), 64'd5);
        check("both_rdata_held", 64'(read_data), 64'h0000_0011);
        check("both_rdata64_held", read_data64, 64'h0000_00AB_0000_0011);
        drop_req();
        check("both_mem2", 64'(mem[2]), 64'd7);

        // Back-to-back write then read of word 3
        run_access(1'b0, 1'b1, 32'd1036, 32'd9, 17'd3, edges, we_lo);
        rd_en   = 1'b1;
        wr_en   = 1'b0;
        address = 32'd1036;
        tick();
        check("b2b_idle_ready", 64'(ready), 64'd0);
        check("b2b_idle_we_n", 64'(sram_we_n), 64'd1);
        check("b2b_mem3", 64'(mem[3]), 64'd9);
        run_access(1'b1, 1'b0, 32'd1036, 32'd0, 17'd3, edges, we_lo);
        check("b2b_rd_latency", 64'(edges), 64'd6);
        check("b2b_rdata", 64'(read_data), 64'd9);
        check("b2b_rdata64", read_data64, 64'h0000_0009_0000_0007);
        drop_req();

        // Reset in the middle of a read (counter at 2)
        rd_en   = 1'b1;
        address = 32'd1032;
        tick();
        tick();
        tick();
        check("mid_busy_ready", 64'(ready), 64'd0);
        rd_en = 1'b0;
        rst   = 1'b1;
        #1;
        check("arst_ready", 64'(ready), 64'd1);
        check("arst_we_n", 64'(sram_we_n), 64'd1);
        check("arst_addr", 64'(sram_addr), 64'd0);
        check("arst_rdata", 64'(read_data), 64'd0);
        check("arst_rdata64", read_data64, 64'd0);
        check("arst_dq", sram_dq, 64'h0000_00AB_0000_0011);
        tick();
        rst = 1'b0;
        tick();
        run_access(1'b1, 1'b0, 32'd1032, 32'd0, 17'd2, edges, we_lo);
        check("post_rst_latency", 64'(edges), 64'd6);
        check("post_rst_rdata", 64'(read_data), 64'd7);
        check("post_rst_rdata64", read_data64, 64'h0000_0009_0000_0007);
        drop_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
